// File: rtl/ltc2195_spi_responder.sv
// LTC2195-style SPI configuration responder (device side of the ADC config port).
// Mode 0, 16-bit frames MSB first: R/W (1 = read), 7-bit address, 8-bit data.
// Optional macro LTC2195_SPI_READBACK_EN enables SDO readback; when it is undefined,
// SDO/OE are tied low and read frames complete silently.
module ltc2195_spi_responder #(
   parameter int unsigned        NREGS        = 5,
   parameter logic [8*NREGS-1:0] REG_DEFAULTS = '0,
   parameter int unsigned        SYNC_STAGES  = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               spi_scs_in,
   input  logic               spi_sck_in,
   input  logic               spi_sdi_in,
   output logic               spi_sdo_out,
   output logic               spi_sdo_oe_out,
   output logic [8*NREGS-1:0] regs_out,
   output logic               wr_strobe_out,
   output logic [6:0]         wr_addr_out,
   output logic               frame_err_out,
   output logic               busy_out
);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

   localparam logic [7:0] NRegsW = 8'(NREGS);

   logic [SYNC_STAGES-1:0] scs_sync_q, sck_sync_q, sdi_sync_q;
   logic                   scs_prev_q, sck_prev_q;
   logic                   scs_s, sck_s, sdi_s;
   logic                   scs_fall, scs_rise, sck_rise, sck_fall;

   state_e             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [7:0]         sr_q, sr_d;
   logic               rw_q, rw_d;
   logic [6:0]         addr_q, addr_d;
   logic [8*NREGS-1:0] regs_q, regs_d;
   logic               strobe_q, strobe_d;
   logic [6:0]         waddr_q, waddr_d;
   logic               err_q, err_d;
   logic [7:0]         wr_data;
   logic               addr_ok;

   assign scs_s    = scs_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
   assign scs_fall = ~scs_s & scs_prev_q;
   assign scs_rise = scs_s & ~scs_prev_q;
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;

   // Synchronize SPI pins and keep one previous sample for edge detection. SCS resets low so
   // a frame already in flight at reset release is not seen until SCS rises and falls again.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         scs_sync_q <= '0;
         sck_sync_q <= '0;
         sdi_sync_q <= '0;
         scs_prev_q <= 1'b0;
         sck_prev_q <= 1'b0;
      end else begin
         scs_sync_q <= {scs_sync_q[SYNC_STAGES-2:0], spi_scs_in};
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_in};
         sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_in};
         scs_prev_q <= scs_s;
         sck_prev_q <= sck_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Frame decode, write commit and soft reset.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      regs_d   = regs_q;
      strobe_d = 1'b0;
      waddr_d  = waddr_q;
      err_d    = 1'b0;
      wr_data  = {sr_q[6:0], sdi_s};
      addr_ok  = ({1'b0, addr_q} < NRegsW);
      unique case (state_q)
         StIdle: begin
            if (scs_fall) begin
               state_d = StAddr;
               cnt_d   = '0;
               sr_d    = '0;
            end
         end
         StAddr, StData: begin
            if (scs_rise) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end else if (sck_rise) begin
               sr_d  = wr_data;
               cnt_d = cnt_q + 5'd1;
               if (state_q == StAddr && cnt_q == 5'd7) begin
                  state_d = StData;
                  rw_d    = wr_data[7];
                  addr_d  = wr_data[6:0];
               end else if (state_q == StData && cnt_q == 5'd15) begin
                  state_d = StDone;
                  if (!rw_q) begin
                     if (addr_ok) begin
                        strobe_d = 1'b1;
                        waddr_d  = addr_q;
                        if (addr_q == 7'd0 && wr_data[7]) begin
                           // Soft reset: restore defaults, reg0 self-clears.
                           regs_d      = REG_DEFAULTS;
                           regs_d[7:0] = 8'h00;
                        end else begin
                           for (int unsigned i = 0; i < NREGS; i++) begin
                              if (addr_q == 7'(i)) regs_d[8*i +: 8] = wr_data;
                           end
                        end
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               end
            end
         end
         StDone: begin
            if (scs_rise) state_d = StIdle;
         end
      endcase
   end

   // Datapath registers and output pulses.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q    <= '0;
         sr_q     <= '0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         regs_q   <= REG_DEFAULTS;
         strobe_q <= 1'b0;
         waddr_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         regs_q   <= regs_d;
         strobe_q <= strobe_d;
         waddr_q  <= waddr_d;
         err_q    <= err_d;
      end
   end

   assign regs_out      = regs_q;
   assign wr_strobe_out = strobe_q;
   assign wr_addr_out   = waddr_q;
   assign frame_err_out = err_q;
   assign busy_out      = (state_q != StIdle);

`ifdef LTC2195_SPI_READBACK_EN
   logic [7:0] so_q, so_d;
   logic       oe_q, oe_d;
   logic [7:0] rd_data;

   // Shift-out register: load on the first SCK fall of the data phase, then shift left.
   always_comb begin
      so_d    = so_q;
      oe_d    = oe_q;
      rd_data = 8'h00;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (addr_q == 7'(i)) rd_data = regs_q[8*i +: 8];
      end
      if (scs_rise) begin
         oe_d = 1'b0;
      end else if (state_q == StIdle && scs_fall) begin
         so_d = '0;
      end else if (state_q == StData && sck_fall && rw_q) begin
         if (cnt_q == 5'd8) begin
            so_d = rd_data;
            oe_d = 1'b1;
         end else if (cnt_q > 5'd8) begin
            so_d = {so_q[6:0], 1'b0};
         end
      end
   end

   // Shift-out state.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         so_q <= '0;
         oe_q <= 1'b0;
      end else begin
         so_q <= so_d;
         oe_q <= oe_d;
      end
   end

   assign spi_sdo_out    = so_q[7];
   assign spi_sdo_oe_out = oe_q;
`else
   assign spi_sdo_out    = 1'b0;
   assign spi_sdo_oe_out = 1'b0;
`endif

endmodule

// File: doc/ltc2195_spi_responder.md
Name: ltc2195_spi_responder

Overview:
- SPI responder that models the ADC configuration register interface from the device side.
- Sits opposite the ADC SPI initiator: in simulation it stands in for the LTC2195 so initiator command sequences can be checked.
- On hardware it can take host configuration over SPI and expose a register bank to fabric.
- Frame: mode 0, 16 bits MSB first = R/W bit (1 = read), 7-bit address, 8-bit data.

Parameters:
- NREGS, 5, number of implemented registers (addresses 0..NREGS-1; max 128).
- REG_DEFAULTS, 40'h0, flat 8*NREGS reset/soft-reset values; register i = bits [8i+7:8i].
- SYNC_STAGES, 2, synchronizer depth on spi_scs_in, spi_sck_in and spi_sdi_in (minimum 2).

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  asynchronous, active-low reset.
- spi_scs_in  input  1  chip select, active low.
- spi_sck_in  input  1  SPI clock, idle low.
- spi_sdi_in  input  1  serial data from initiator.
- spi_sdo_out  output  1  serial read data.
- spi_sdo_oe_out  output  1  high while driving spi_sdo_out.
- regs_out  output  8*NREGS  current register contents, flat.
- wr_strobe_out  output  1  one-cycle pulse per committed write.
- wr_addr_out  output  7  address of the last committed write.
- frame_err_out  output  1  one-cycle pulse on an aborted or out-of-range frame.
- busy_out  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; bit counter 0; regs_out = REG_DEFAULTS; spi_sdo_out = 0; spi_sdo_oe_out = 0; wr_strobe_out = 0; wr_addr_out = 0; frame_err_out = 0; busy_out = 0.
- Input sampling: all SPI inputs pass through SYNC_STAGES flops, then one edge-detect flop.
  - SCK edges are acted on SYNC_STAGES+1 clk_in cycles after the pin edge.
  - Constraint: SCK high and low times must each be at least SYNC_STAGES+2 clk_in cycles (12.5 MHz max at defaults). Faster SCK is unsupported.
- State machine: IDLE -> ADDR -> DATA -> DONE.
  - IDLE -> ADDR: synchronized SCS falls; busy_out = 1; counter cleared.
  - ADDR: SDI shifted in on each SCK rising edge; after the 8th bit, latch R/W and address, then go to DATA.
  - DATA: 8 more rising edges.
    - Write: shift SDI into the data register.
    - Read: drive spi_sdo_out from shift-out register.
  - After the 16th rising edge -> DONE. Further SCK edges are ignored.
  - Any state -> IDLE on SCS rise; busy_out = 0 and spi_sdo_oe_out = 0 in the same cycle.
- Read (R/W = 1):
  - On the SCK falling edge after the 8th bit, load the shift-out register with reg[addr] (0x00 if addr >= NREGS), drive its MSB and set spi_sdo_oe_out.
  - On each subsequent falling edge, shift left by one bit.
- Write commit, on the 16th rising edge with R/W = 0:
  - addr < NREGS: reg[addr] updated; wr_addr_out = addr; wr_strobe_out pulses on the next clk_in cycle.
  - addr >= NREGS: no register change; frame_err_out pulses.
- Soft reset: writing to address 0 with data bit 7 = 1 loads all registers with REG_DEFAULTS, except reg0, which is forced to 0x00 (self-clearing). wr_strobe_out still pulses with wr_addr_out = 0.
- Aborted frame: SCS rises in ADDR or DATA before 16 bits.
  - No write occurs and frame_err_out pulses.
  - An SCS rise in DONE is a normal end, with no error.
- Back-to-back frames: SCS high for at least SYNC_STAGES+2 cycles is recognized. Counter and shift registers clear on each SCS fall.
- Reset asserted mid-frame: immediate return to reset values. A frame already in progress is ignored until SCS goes high, then falls again.

Optional Feature:
- Macro: LTC2195_SPI_READBACK_EN.
- Defined: read frames behave as described above.
- Undefined:
  - spi_sdo_out and spi_sdo_oe_out are tied to 0.
  - Read frames are decoded and completed with no register change, no strobe and no error.
  - Shift-out logic is not synthesized.

Test Plan:
- Write 0x00_00 style frame 16'h01_A5 (R/W 0, addr 1, data A5) at SCK = 10 MHz -> regs_out[15:8] = 0xA5; one wr_strobe_out pulse; wr_addr_out = 1; no frame_err_out.
- Write addr 1 = 0x3C, then read frame 16'h81_00 -> SDO bits sampled on SCK rising edges 9..16 = 0x3C; spi_sdo_oe_out high only during the data phase.
- Write 16'h00_80 after regs 1..4 have been modified -> regs_out = REG_DEFAULTS with reg0 = 0x00; one strobe with addr 0.
- SCS raised after 11 SCK edges of a write frame to addr 2 -> reg2 unchanged; frame_err_out pulses once; busy_out returns to 0.
- Write to addr 7 with NREGS = 5 -> no change; frame_err_out pulses. Read of addr 7 returns 0x00.
- rst_in pulsed low during the DATA phase of a write -> regs_out = REG_DEFAULTS, no strobe. The next full frame after SCS toggles completes normally.
